data_memory_ctrl: RTL and testbench

//  Parametrised successor to the single-cycle data memory: word-array RAM behind a valid/ready

---
 rtl/mem_access_pkg.sv | 18 +
 rtl/load_store_align.sv | 58 +++++
 rtl/data_memory_ctrl.sv | 134 +++++++++++++
 tb/tb_data_memory_ctrl.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/mem_access_pkg.sv
// Shared types for the data memory controller: RV32I load/store width codes and FSM states.
package mem_access_pkg;

   typedef enum logic [2:0] {
      MEM_B  = 3'b000,
      MEM_H  = 3'b001,
      MEM_W  = 3'b010,
      MEM_BU = 3'b100,
      MEM_HU = 3'b101
   } mem_funct3_t;

   typedef enum logic [1:0] {
      MC_IDLE,
      MC_WAIT,
      MC_RESP
   } mem_ctrl_state_t;

endpackage

// File: rtl/load_store_align.sv
// Combinational RV32I sub-word lane logic: load extraction/extension, store merge and fault detection.
module load_store_align
   import mem_access_pkg::*;
(
   input  logic [31:0] word,
   input  logic [31:0] wdata,
   input  logic [2:0]  funct3,
   input  logic [1:0]  offset,
   input  logic        write,
   output logic [31:0] load_data,
   output logic [31:0] store_word,
   output logic        fault
);

   logic [4:0]  shamt;
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      shamt      = {offset, 3'b000};
      byte_sel   = 8'(word >> shamt);
      half_sel   = offset[1] ? word[31:16] : word[15:0];
      load_data  = '0;
      store_word = word;
      fault      = 1'b0;
      case (funct3)
         MEM_B: begin
            load_data  = {{24{byte_sel[7]}}, byte_sel};
            store_word = (word & ~(32'h0000_00FF << shamt)) | ({24'b0, wdata[7:0]} << shamt);
         end
         MEM_H: begin
            fault      = offset[0];
            load_data  = {{16{half_sel[15]}}, half_sel};
            store_word = offset[1] ? {wdata[15:0], word[15:0]} : {word[31:16], wdata[15:0]};
         end
         MEM_W: begin
            fault      = (offset != 2'b00);
            load_data  = word;
            store_word = wdata;
         end
         // unsigned widths have no store form
         MEM_BU: begin
            fault     = write;
            load_data = {24'b0, byte_sel};
         end
         MEM_HU: begin
            fault     = write | offset[0];
            load_data = {16'b0, half_sel};
         end
         default: fault = 1'b1;
      endcase
      if (fault) begin
         load_data  = '0;
         store_word = word;
      end
   end

endmodule

// File: rtl/data_memory_ctrl.sv
// Word-array data RAM behind a valid/ready port with fixed access latency and RV32I sub-word access.
module data_memory_ctrl
   import mem_access_pkg::*;
#(
   parameter int DEPTH   = 32,
   parameter int LATENCY = 1
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   req_valid,
   output logic                   req_ready,
   input  logic                   req_write,
   input  logic [2:0]             req_funct3,
   input  logic [31:0]            req_addr,
   input  logic [31:0]            req_wdata,
   output logic                   resp_valid,
   output logic [31:0]            resp_rdata,
   output logic                   resp_fault,
   input  logic [DEPTH-1:0][31:0] initial_values,
   output logic [DEPTH-1:0][31:0] memory_check
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
   localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'((LATENCY > 1) ? LATENCY - 2 : 0);

   mem_ctrl_state_t state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             accept, enter_resp;

   logic             q_write;
   logic [2:0]       q_funct3;
   logic [IDX_W+1:0] q_addr;
   logic [31:0]      q_wdata;

   logic [31:0]      mem [DEPTH];

   logic             use_live, a_write;
   logic [2:0]       a_funct3;
   logic [IDX_W+1:0] a_addr;
   logic [31:0]      a_wdata;
   logic [IDX_W-1:0] idx;
   logic [31:0]      load_data, store_word;
   logic             fault;

   // Upper address bits alias onto the array; they carry no meaning here.
   logic unused_addr_bits;
   assign unused_addr_bits = &{1'b0, req_addr[31:IDX_W+2]};

   assign req_ready = (state != MC_WAIT);
   assign accept    = req_valid && req_ready;

   always_comb begin
      state_nxt  = state;
      cnt_nxt    = cnt;
      enter_resp = 1'b0;
      case (state)
         MC_IDLE, MC_RESP: begin
            if (accept) begin
               if (LATENCY == 1) begin
                  state_nxt  = MC_RESP;
                  enter_resp = 1'b1;
               end else begin
                  state_nxt = MC_WAIT;
                  cnt_nxt   = '0;
               end
            end else begin
               state_nxt = MC_IDLE;
            end
         end
         MC_WAIT: begin
            if (cnt == WAIT_LAST) begin
               state_nxt  = MC_RESP;
               enter_resp = 1'b1;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         default: state_nxt = MC_IDLE;
      endcase
   end

   // With single-cycle latency the access completes on the accept edge, so it uses the live request.
   assign use_live = (state != MC_WAIT);
   assign a_write  = use_live ? req_write               : q_write;
   assign a_funct3 = use_live ? req_funct3              : q_funct3;
   assign a_addr   = use_live ? req_addr[IDX_W+1:0]     : q_addr;
   assign a_wdata  = use_live ? req_wdata               : q_wdata;
   assign idx      = a_addr[IDX_W+1:2];

   load_store_align u_align (
      .word       (mem[idx]),
      .wdata      (a_wdata),
      .funct3     (a_funct3),
      .offset     (a_addr[1:0]),
      .write      (a_write),
      .load_data  (load_data),
      .store_word (store_word),
      .fault      (fault)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= MC_IDLE;
         cnt        <= '0;
         q_write    <= 1'b0;
         q_funct3   <= '0;
         q_addr     <= '0;
         q_wdata    <= '0;
         resp_valid <= 1'b0;
         resp_rdata <= '0;
         resp_fault <= 1'b0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= initial_values[i];
      end else begin
         state      <= state_nxt;
         cnt        <= cnt_nxt;
         if (accept) begin
            q_write  <= req_write;
            q_funct3 <= req_funct3;
            q_addr   <= req_addr[IDX_W+1:0];
            q_wdata  <= req_wdata;
         end
         resp_valid <= enter_resp;
         resp_fault <= enter_resp && fault;
         resp_rdata <= (enter_resp && !a_write) ? load_data : '0;
         if (enter_resp && a_write && !fault) mem[idx] <= store_word;
      end
   end

   for (genvar g = 0; g < DEPTH; g++) begin : g_check
      assign memory_check[g] = mem[g];
   end

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Directed bench: one controller at LATENCY=1 for data/fault paths, one at LATENCY=3 for timing and abort.
module tb_data_memory_ctrl;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   logic              a_valid, a_write, a_ready, a_rvalid, a_fault;
   logic [2:0]        a_f3;
   logic [31:0]       a_addr, a_wdata, a_rdata;
   logic [31:0][31:0] a_img, a_mem;

   logic              b_valid, b_write, b_ready, b_rvalid, b_fault;
   logic [2:0]        b_f3;
   logic [31:0]       b_addr, b_wdata, b_rdata;
   logic [31:0][31:0] b_img, b_mem;

   int tests = 0;
   int fails = 0;

   data_memory_ctrl #(.DEPTH(32), .LATENCY(1)) dut_a (
      .clk(clk), .reset(reset), .req_valid(a_valid), .req_ready(a_ready), .req_write(a_write),
      .req_funct3(a_f3), .req_addr(a_addr), .req_wdata(a_wdata), .resp_valid(a_rvalid),
      .resp_rdata(a_rdata), .resp_fault(a_fault), .initial_values(a_img), .memory_check(a_mem)
   );

   data_memory_ctrl #(.DEPTH(32), .LATENCY(3)) dut_b (
      .clk(clk), .reset(reset), .req_valid(b_valid), .req_ready(b_ready), .req_write(b_write),
      .req_funct3(b_f3), .req_addr(b_addr), .req_wdata(b_wdata), .resp_valid(b_rvalid),
      .resp_rdata(b_rdata), .resp_fault(b_fault), .initial_values(b_img), .memory_check(b_mem)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Issue one request to the LATENCY=1 instance; returns at the negedge of its response cycle.
   task automatic acc_a(input logic w, input logic [2:0] f3, input logic [31:0] ad, input logic [31:0] wd);
      @(negedge clk);
      a_valid = 1'b1; a_write = w; a_f3 = f3; a_addr = ad; a_wdata = wd;
      @(negedge clk);
      a_valid = 1'b0;
   endtask

   task automatic resp_a(input string tag, input logic [31:0] rdata, input logic flt);
      chk({tag, "_rdata"}, a_rdata, rdata);
      chk({tag, "_vf"}, {30'b0, a_rvalid, a_fault}, {30'b0, 1'b1, flt});
   endtask

   initial begin
      logic seen;
      reset = 1'b1;
      a_valid = 1'b0; a_write = 1'b0; a_f3 = '0; a_addr = '0; a_wdata = '0;
      b_valid = 1'b0; b_write = 1'b0; b_f3 = '0; b_addr = '0; b_wdata = '0;
      a_img = '0; b_img = '0;
      a_img[1] = 32'h8001_7FFF;
      a_img[2] = 32'h5555_AAAA;
      b_img[2] = 32'h1122_3344;
      repeat (2) @(negedge clk);
      reset = 1'b0;

      chk("rst_ready", {31'b0, a_ready}, 32'd1);
      chk("rst_valid", {31'b0, a_rvalid}, 32'd0);
      chk("rst_rdata", a_rdata, 32'd0);
      chk("rst_mem1", a_mem[1], 32'h8001_7FFF);

      // loads from mem[1] = 0x8001_7FFF
      acc_a(1'b0, 3'b010, 32'h4, '0);  resp_a("lw",  32'h8001_7FFF, 1'b0);
      acc_a(1'b0, 3'b001, 32'h6, '0);  resp_a("lh",  32'hFFFF_8001, 1'b0);
      acc_a(1'b0, 3'b101, 32'h6, '0);  resp_a("lhu", 32'h0000_8001, 1'b0);
      acc_a(1'b0, 3'b000, 32'h4, '0);  resp_a("lb",  32'hFFFF_FFFF, 1'b0);
      acc_a(1'b0, 3'b000, 32'h5, '0);  resp_a("lb5", 32'h0000_007F, 1'b0);
      acc_a(1'b0, 3'b100, 32'h5, '0);  resp_a("lbu", 32'h0000_007F, 1'b0);
      acc_a(1'b0, 3'b010, 32'h84, '0); resp_a("alias", 32'h8001_7FFF, 1'b0);
      @(negedge clk);
      chk("pulse_valid", {31'b0, a_rvalid}, 32'd0);
      chk("pulse_rdata", a_rdata, 32'd0);

      // back-to-back accepts from RESP
      @(negedge clk);
      a_valid = 1'b1; a_write = 1'b0; a_f3 = 3'b010; a_addr = 32'h8;
      @(negedge clk);
      chk("b2b_ready", {31'b0, a_ready}, 32'd1);
      resp_a("b2b_lw", 32'h5555_AAAA, 1'b0);
      a_f3 = 3'b100; a_addr = 32'h5;
      @(negedge clk);
      a_valid = 1'b0;
      resp_a("b2b_lbu", 32'h0000_007F, 1'b0);

      // stores with read-modify-write
      acc_a(1'b1, 3'b010, 32'h4, 32'h0);
      resp_a("sw", 32'h0, 1'b0);
      chk("sw_mem", a_mem[1], 32'h0);
      acc_a(1'b1, 3'b000, 32'h5, 32'h1234_56AB);
      chk("sb_mem", a_mem[1], 32'h0000_AB00);
      acc_a(1'b1, 3'b001, 32'h6, 32'h0000_BEEF);
      chk("sh_mem", a_mem[1], 32'hBEEF_AB00);
      acc_a(1'b0, 3'b000, 32'h5, '0);  resp_a("lb_st",  32'hFFFF_FFAB, 1'b0);
      acc_a(1'b0, 3'b101, 32'h6, '0);  resp_a("lhu_st", 32'h0000_BEEF, 1'b0);

      // faults
      acc_a(1'b0, 3'b010, 32'h2, '0);  resp_a("f_lw2", 32'h0, 1'b1);
      acc_a(1'b1, 3'b010, 32'h6, 32'hFFFF_FFFF);
      resp_a("f_sw6", 32'h0, 1'b1);
      chk("f_sw6_mem", a_mem[1], 32'hBEEF_AB00);
      acc_a(1'b0, 3'b011, 32'h4, '0);  resp_a("f_f3_011", 32'h0, 1'b1);
      acc_a(1'b0, 3'b001, 32'h5, '0);  resp_a("f_lh5", 32'h0, 1'b1);
      acc_a(1'b1, 3'b100, 32'h4, 32'hFFFF_FFFF);
      resp_a("f_sbu", 32'h0, 1'b1);
      chk("f_sbu_mem", a_mem[1], 32'hBEEF_AB00);

      // LATENCY=3 timing on a store
      @(negedge clk);
      b_valid = 1'b1; b_write = 1'b1; b_f3 = 3'b010; b_addr = 32'h8; b_wdata = 32'hCAFE_F00D;
      @(negedge clk);
      b_valid = 1'b0;
      chk("l3_c1", {30'b0, b_ready, b_rvalid}, 32'b00);
      @(negedge clk);
      chk("l3_c2", {30'b0, b_ready, b_rvalid}, 32'b00);
      chk("l3_c2_mem", b_mem[2], 32'h1122_3344);
      @(negedge clk);
      chk("l3_c3", {30'b0, b_ready, b_rvalid}, 32'b11);
      chk("l3_c3_mem", b_mem[2], 32'hCAFE_F00D);
      @(negedge clk);
      chk("l3_c4", {31'b0, b_rvalid}, 32'd0);

      // LATENCY=3 load
      b_valid = 1'b1; b_write = 1'b0; b_f3 = 3'b010; b_addr = 32'h8;
      @(negedge clk);
      b_valid = 1'b0;
      repeat (2) @(negedge clk);
      chk("l3_lw", b_rdata, 32'hCAFE_F00D);
      chk("l3_lw_v", {31'b0, b_rvalid}, 32'd1);

      // reset during WAIT of a store aborts it
      @(negedge clk);
      b_valid = 1'b1; b_write = 1'b1; b_f3 = 3'b010; b_addr = 32'h8; b_wdata = 32'h1234_5678;
      @(negedge clk);
      b_valid = 1'b0;
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("abort_ready", {31'b0, b_ready}, 32'd1);
      chk("abort_mem", b_mem[2], 32'h1122_3344);
      seen = b_rvalid;
      repeat (4) begin
         @(negedge clk);
         seen = seen | b_rvalid;
      end
      chk("abort_noresp", {31'b0, seen}, 32'd0);
      chk("abort_mem2", b_mem[2], 32'h1122_3344);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
